// File: rtl/store_unit_pkg.sv
// Shared types for the store execution pipe: SQ packet, byte mask, ROB tag,
// branch mask and the memory access size encoding.
// Build option: STORE_MISALIGN_CHECK_EN (see store_align / store_unit).
`ifndef SQ_SZ
`define SQ_SZ 8
`endif
`ifndef BRANCH_PRED_SZ
`define BRANCH_PRED_SZ 4
`endif

package store_unit_pkg;
  localparam int ROB_TAG_W = 5;

  typedef logic [ROB_TAG_W-1:0]       rob_tag_t;
  typedef logic [3:0]                 byte_mask_t;
  typedef logic [`BRANCH_PRED_SZ-1:0] branch_mask_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [31:0] store_addr;
    byte_mask_t  byte_mask;
    logic [31:0] store_result;
  } sq_packet_t;
endpackage

// File: rtl/store_unit_align.sv
// store_align: combinational byte-mask / lane-alignment generator.
// STORE_MISALIGN_CHECK_EN defined: misaligned half/word keep their raw address,
// get an all-zero byte mask and raise o_misalign. Undefined: low address bits
// are truncated to the natural alignment of the access.
module store_align
  import store_unit_pkg::*;
(
  input  logic [31:0] i_addr,
  input  mem_size_e   i_size,
  input  logic [31:0] i_data,
  output logic [31:0] o_addr,
  output byte_mask_t  o_mask,
  output logic [31:0] o_data
`ifdef STORE_MISALIGN_CHECK_EN
  ,
  output logic        o_misalign
`endif
);

  logic w_mis;

  // mask, data lane shift and aligned address per access size
  always_comb begin
    o_addr = i_addr;
    o_mask = 4'hF;
    o_data = i_data;
    w_mis  = 1'b0;
    case (i_size)
      BYTE: begin
        o_mask = 4'b0001 << i_addr[1:0];
        o_data = i_data << {i_addr[1:0], 3'b000};
      end
      HALF: begin
        o_mask = 4'b0011 << {i_addr[1], 1'b0};
        o_data = i_data << {i_addr[1], 4'b0000};
        o_addr = {i_addr[31:1], 1'b0};
        w_mis  = i_addr[0];
      end
      default: begin
        o_addr = {i_addr[31:2], 2'b00};
        w_mis  = |i_addr[1:0];
      end
    endcase
`ifdef STORE_MISALIGN_CHECK_EN
    // keep the faulting address visible and make sure nothing is written
    if (w_mis) begin
      o_addr = i_addr;
      o_mask = 4'b0000;
    end
`endif
  end

`ifdef STORE_MISALIGN_CHECK_EN
  assign o_misalign = w_mis;
`endif

endmodule

// File: rtl/store_unit.sv
// store_unit: two-stage store execution pipe (issue -> S1 addr gen/align ->
// S2 -> SQ write + ROB completion). Stages carry a branch mask and are
// squashed on mispredict. Build option: STORE_MISALIGN_CHECK_EN enables the
// misaligned-store exception; otherwise st_complete_exc is tied low.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int SQ_SZ   = `SQ_SZ,
  parameter int BMASK_W = `BRANCH_PRED_SZ
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     st_issue_valid,
  output logic                     st_issue_ready,
  input  logic [31:0]              st_issue_base,
  input  logic [31:0]              st_issue_imm,
  input  logic [31:0]              st_issue_data,
  input  logic [1:0]               st_issue_size,
  input  logic [$clog2(SQ_SZ)-1:0] st_issue_sq_idx,
  input  rob_tag_t                 st_issue_rob_tag,
  input  logic [BMASK_W-1:0]       st_issue_bmask,
  input  logic                     b_mispredict_valid,
  input  logic [BMASK_W-1:0]       b_mispredict_mask,
  input  logic                     b_resolve_valid,
  input  logic [BMASK_W-1:0]       b_resolve_mask,
  output sq_packet_t               sq_packet,
  output logic [SQ_SZ-1:0]         resolving_sq_mask,
  output logic                     st_complete_valid,
  output rob_tag_t                 st_complete_rob_tag,
  output logic                     st_complete_exc,
  input  logic                     st_complete_ack
);

  localparam int IDX_W = $clog2(SQ_SZ);

  typedef struct packed {
    logic [31:0]        base;
    logic [31:0]        imm;
    logic [31:0]        data;
    logic [1:0]         size;
    logic [IDX_W-1:0]   sq_idx;
    rob_tag_t           tag;
    logic [BMASK_W-1:0] bmask;
  } s1_t;

  typedef struct packed {
    sq_packet_t         pkt;
    logic [IDX_W-1:0]   sq_idx;
    rob_tag_t           tag;
    logic [BMASK_W-1:0] bmask;
`ifdef STORE_MISALIGN_CHECK_EN
    logic               misalign;
`endif
  } s2_t;

  logic               r_s1_valid;
  logic               r_s2_valid;
  s1_t                r_s1;
  s2_t                r_s2;

  logic [BMASK_W-1:0] w_res_clr;
  logic               w_iss_sq;
  logic               w_s1_sq;
  logic               w_s2_sq;
  logic               w_fire;
  logic               w_s2_adv;
  logic               w_s1_adv;
  logic [31:0]        w_s1_addr;
  logic [31:0]        w_al_addr;
  byte_mask_t         w_al_mask;
  logic [31:0]        w_al_data;
`ifdef STORE_MISALIGN_CHECK_EN
  logic               w_al_mis;
`endif

  assign w_res_clr = b_resolve_valid ? b_resolve_mask : '0;
  assign w_iss_sq  = b_mispredict_valid && |(st_issue_bmask & b_mispredict_mask);
  assign w_s1_sq   = b_mispredict_valid && |(r_s1.bmask & b_mispredict_mask);
  assign w_s2_sq   = b_mispredict_valid && |(r_s2.bmask & b_mispredict_mask);

  assign w_fire    = r_s2_valid && !w_s2_sq && st_complete_ack;
  assign w_s2_adv  = !r_s2_valid || w_fire || w_s2_sq;
  assign w_s1_adv  = !r_s1_valid || w_s1_sq || w_s2_adv;

  assign w_s1_addr = r_s1.base + r_s1.imm;

  store_align u_align (
    .i_addr     (w_s1_addr),
    .i_size     (mem_size_e'(r_s1.size)),
    .i_data     (r_s1.data),
    .o_addr     (w_al_addr),
    .o_mask     (w_al_mask),
    .o_data     (w_al_data)
`ifdef STORE_MISALIGN_CHECK_EN
    ,
    .o_misalign (w_al_mis)
`endif
  );

  // S1: capture issue fields; hold behind a stalled S2 while resolving bmask bits
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= st_issue_valid && !w_iss_sq;
      if (st_issue_valid) begin
        r_s1.base   <= st_issue_base;
        r_s1.imm    <= st_issue_imm;
        r_s1.data   <= st_issue_data;
        r_s1.size   <= st_issue_size;
        r_s1.sq_idx <= st_issue_sq_idx;
        r_s1.tag    <= st_issue_rob_tag;
        r_s1.bmask  <= st_issue_bmask & ~w_res_clr;
      end else begin
        r_s1.bmask  <= '0;
      end
    end else begin
      r_s1.bmask <= r_s1.bmask & ~w_res_clr;
    end
  end

  // S2: take the aligned entry from S1 or hold until the ROB acks
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid && !w_s1_sq;
      if (r_s1_valid) begin
        r_s2.pkt.store_addr   <= w_al_addr;
        r_s2.pkt.byte_mask    <= w_al_mask;
        r_s2.pkt.store_result <= w_al_data;
        r_s2.sq_idx           <= r_s1.sq_idx;
        r_s2.tag              <= r_s1.tag;
        r_s2.bmask            <= r_s1.bmask & ~w_res_clr;
`ifdef STORE_MISALIGN_CHECK_EN
        r_s2.misalign         <= w_al_mis;
`endif
      end else begin
        r_s2.bmask <= '0;
      end
    end else begin
      r_s2.bmask <= r_s2.bmask & ~w_res_clr;
    end
  end

  assign st_issue_ready      = w_s1_adv;
  assign st_complete_valid   = r_s2_valid && !w_s2_sq;
  assign st_complete_rob_tag = r_s2.tag;
  assign sq_packet           = r_s2.pkt;
  assign resolving_sq_mask   = w_fire ? ({{(SQ_SZ-1){1'b0}}, 1'b1} << r_s2.sq_idx) : '0;
`ifdef STORE_MISALIGN_CHECK_EN
  assign st_complete_exc     = st_complete_valid && r_s2.misalign;
`else
  assign st_complete_exc     = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a scoreboard of expected SQ writes.
// Honours STORE_MISALIGN_CHECK_EN the same way the design does.
module tb_store_unit;
  import store_unit_pkg::*;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        st_issue_valid, st_issue_ready;
  logic [31:0] st_issue_base, st_issue_imm, st_issue_data;
  logic [1:0]  st_issue_size;
  logic [2:0]  st_issue_sq_idx;
  rob_tag_t    st_issue_rob_tag;
  logic [3:0]  st_issue_bmask;
  logic        b_mispredict_valid, b_resolve_valid;
  logic [3:0]  b_mispredict_mask, b_resolve_mask;
  sq_packet_t  sq_packet;
  logic [7:0]  resolving_sq_mask;
  logic        st_complete_valid, st_complete_exc, st_complete_ack;
  rob_tag_t    st_complete_rob_tag;

  store_unit dut (
    .clock(clock), .reset(reset),
    .st_issue_valid(st_issue_valid), .st_issue_ready(st_issue_ready),
    .st_issue_base(st_issue_base), .st_issue_imm(st_issue_imm),
    .st_issue_data(st_issue_data), .st_issue_size(st_issue_size),
    .st_issue_sq_idx(st_issue_sq_idx), .st_issue_rob_tag(st_issue_rob_tag),
    .st_issue_bmask(st_issue_bmask),
    .b_mispredict_valid(b_mispredict_valid), .b_mispredict_mask(b_mispredict_mask),
    .b_resolve_valid(b_resolve_valid), .b_resolve_mask(b_resolve_mask),
    .sq_packet(sq_packet), .resolving_sq_mask(resolving_sq_mask),
    .st_complete_valid(st_complete_valid), .st_complete_rob_tag(st_complete_rob_tag),
    .st_complete_exc(st_complete_exc), .st_complete_ack(st_complete_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] res;
    logic [2:0]  idx;
    logic [4:0]  tag;
    logic        exc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference: what the SQ should receive for one store
  function automatic exp_t model(logic [31:0] b, logic [31:0] i, logic [31:0] d,
                                 logic [1:0] sz, logic [2:0] idx, logic [4:0] tg);
    exp_t        e;
    logic [31:0] a;
    int          lane;
    logic        mis;
    a = b + i;
    e.idx = idx;
    e.tag = tg;
    e.exc = 1'b0;
    case (sz)
      2'd0: begin lane = int'(a[1:0]); mis = 1'b0; e.mask = 4'b0001 << lane; e.addr = a; end
      2'd1: begin lane = a[1] ? 2 : 0; mis = a[0]; e.mask = 4'b0011 << lane; e.addr = a & 32'hFFFF_FFFE; end
      default: begin lane = 0; mis = (a[1:0] != 2'b00); e.mask = 4'hF; e.addr = a & 32'hFFFF_FFFC; end
    endcase
    e.res = d << (lane * 8);
`ifdef STORE_MISALIGN_CHECK_EN
    e.addr = a;
    if (mis) begin
      e.mask = 4'h0;
      e.exc  = 1'b1;
    end
`endif
    return e;
  endfunction

  // scoreboard: every SQ write must match the oldest outstanding expectation
  always @(negedge clock) begin
    exp_t e;
    if (!reset && resolving_sq_mask != 8'h00) begin
      chk("sb_complete_valid", {63'd0, st_complete_valid}, 64'd1);
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", {56'd0, resolving_sq_mask}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_slot", {56'd0, resolving_sq_mask}, 64'd1 << e.idx);
        chk("sb_addr", {32'd0, sq_packet.store_addr}, {32'd0, e.addr});
        chk("sb_mask", {60'd0, sq_packet.byte_mask}, {60'd0, e.mask});
        chk("sb_result", {32'd0, sq_packet.store_result}, {32'd0, e.res});
        chk("sb_tag", {59'd0, st_complete_rob_tag}, {59'd0, e.tag});
        chk("sb_exc", {63'd0, st_complete_exc}, {63'd0, e.exc});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic [31:0] b, logic [31:0] i, logic [31:0] d, logic [1:0] sz,
                       logic [2:0] idx, logic [4:0] tg, logic [3:0] bm, bit push);
    st_issue_valid   = 1'b1;
    st_issue_base    = b;
    st_issue_imm     = i;
    st_issue_data    = d;
    st_issue_size    = sz;
    st_issue_sq_idx  = idx;
    st_issue_rob_tag = tg;
    st_issue_bmask   = bm;
    if (push) sb.push_back(model(b, i, d, sz, idx, tg));
  endtask

  initial begin
    reset = 1'b1;
    st_issue_valid = 1'b0; st_issue_base = '0; st_issue_imm = '0; st_issue_data = '0;
    st_issue_size = '0; st_issue_sq_idx = '0; st_issue_rob_tag = '0; st_issue_bmask = '0;
    b_mispredict_valid = 1'b0; b_mispredict_mask = '0;
    b_resolve_valid = 1'b0; b_resolve_mask = '0;
    st_complete_ack = 1'b1;
    repeat (3) step();

    // reset state
    @(negedge clock);
    chk("rst_ready", {63'd0, st_issue_ready}, 64'd1);
    chk("rst_cvalid", {63'd0, st_complete_valid}, 64'd0);
    chk("rst_resolving", {56'd0, resolving_sq_mask}, 64'd0);
    chk("rst_exc", {63'd0, st_complete_exc}, 64'd0);
    chk("rst_pkt_addr", {32'd0, sq_packet.store_addr}, 64'd0);
    chk("rst_pkt_res", {28'd0, sq_packet.byte_mask, sq_packet.store_result}, 64'd0);
    chk("rst_tag", {59'd0, st_complete_rob_tag}, 64'd0);
    step();
    reset = 1'b0;

    // word store, latency 2
    drive(32'h1000, 32'h8, 32'hDEAD_BEEF, 2'd2, 3'd3, 5'd5, 4'b0000, 1'b1);
    step();
    st_issue_valid = 1'b0;
    @(negedge clock);
    chk("word_not_early", {56'd0, resolving_sq_mask}, 64'd0);
    step();
    @(negedge clock);
    chk("word_slot", {56'd0, resolving_sq_mask}, 64'h08);
    chk("word_addr", {32'd0, sq_packet.store_addr}, 64'h1008);
    chk("word_mask", {60'd0, sq_packet.byte_mask}, 64'hF);
    chk("word_result", {32'd0, sq_packet.store_result}, 64'hDEAD_BEEF);
    chk("word_tag", {59'd0, st_complete_rob_tag}, 64'd5);
    step();

    // byte then half, back to back
    drive(32'h1000, 32'h3, 32'h0000_00AB, 2'd0, 3'd1, 5'd6, 4'b0000, 1'b1);
    step();
    drive(32'h1000, 32'h2, 32'h0000_1234, 2'd1, 3'd2, 5'd7, 4'b0000, 1'b1);
    step();
    st_issue_valid = 1'b0;
    @(negedge clock);
    chk("byte_mask", {60'd0, sq_packet.byte_mask}, 64'b1000);
    chk("byte_result", {32'd0, sq_packet.store_result}, 64'hAB00_0000);
    step();
    @(negedge clock);
    chk("half_mask", {60'd0, sq_packet.byte_mask}, 64'b1100);
    chk("half_result", {32'd0, sq_packet.store_result}, 64'h1234_0000);
    step();

    // backpressure: ready drops after two accepts, nothing written while ack low
    st_complete_ack = 1'b0;
    drive(32'h2000, 32'h0, 32'h1111_1111, 2'd2, 3'd4, 5'd10, 4'b0000, 1'b1);
    step();
    drive(32'h2004, 32'h0, 32'h2222_2222, 2'd2, 3'd5, 5'd11, 4'b0000, 1'b1);
    step();
    drive(32'h2008, 32'h0, 32'h3333_3333, 2'd2, 3'd6, 5'd12, 4'b0000, 1'b1);
    @(negedge clock);
    chk("bp_ready_low0", {63'd0, st_issue_ready}, 64'd0);
    chk("bp_no_write0", {56'd0, resolving_sq_mask}, 64'd0);
    step();
    @(negedge clock);
    chk("bp_ready_low1", {63'd0, st_issue_ready}, 64'd0);
    chk("bp_no_write1", {56'd0, resolving_sq_mask}, 64'd0);
    chk("bp_cvalid", {63'd0, st_complete_valid}, 64'd1);
    step();
    st_complete_ack = 1'b1;
    @(negedge clock);
    chk("bp_fire0", {56'd0, resolving_sq_mask}, 64'h10);
    chk("bp_ready_on_ack", {63'd0, st_issue_ready}, 64'd1);
    step();
    st_issue_valid = 1'b0;
    @(negedge clock);
    chk("bp_fire1", {56'd0, resolving_sq_mask}, 64'h20);
    step();
    @(negedge clock);
    chk("bp_fire2", {56'd0, resolving_sq_mask}, 64'h40);
    step();

    // squash the stalled S2 entry while S1 survives
    st_complete_ack = 1'b0;
    drive(32'h3000, 32'h0, 32'h5555_5555, 2'd2, 3'd0, 5'd13, 4'b0010, 1'b0);
    step();
    drive(32'h3004, 32'h0, 32'h6666_6666, 2'd2, 3'd1, 5'd14, 4'b0001, 1'b1);
    step();
    st_issue_valid = 1'b0;
    b_mispredict_valid = 1'b1;
    b_mispredict_mask  = 4'b0010;
    st_complete_ack    = 1'b1;
    @(negedge clock);
    chk("sq_cvalid_dropped", {63'd0, st_complete_valid}, 64'd0);
    chk("sq_no_write", {56'd0, resolving_sq_mask}, 64'd0);
    step();
    b_mispredict_valid = 1'b0;
    @(negedge clock);
    chk("sq_survivor_fires", {56'd0, resolving_sq_mask}, 64'h02);
    step();

    // issue squashed on the cycle it is accepted
    drive(32'h3100, 32'h0, 32'h7777_7777, 2'd2, 3'd2, 5'd15, 4'b0100, 1'b0);
    b_mispredict_valid = 1'b1;
    b_mispredict_mask  = 4'b0100;
    step();
    st_issue_valid = 1'b0;
    b_mispredict_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("iss_sq_no_write", {56'd0, resolving_sq_mask}, 64'd0);
      step();
    end

    // resolve then mispredict of the same bit: entry survives
    drive(32'h4000, 32'h10, 32'h8888_8888, 2'd2, 3'd4, 5'd16, 4'b0001, 1'b1);
    step();
    st_issue_valid  = 1'b0;
    b_resolve_valid = 1'b1;
    b_resolve_mask  = 4'b0001;
    step();
    b_resolve_valid    = 1'b0;
    b_mispredict_valid = 1'b1;
    b_mispredict_mask  = 4'b0001;
    @(negedge clock);
    chk("res_cvalid", {63'd0, st_complete_valid}, 64'd1);
    chk("res_fire", {56'd0, resolving_sq_mask}, 64'h10);
    step();
    b_mispredict_valid = 1'b0;

    // misaligned word at 0x1001
    drive(32'h1000, 32'h1, 32'hCAFE_F00D, 2'd2, 3'd7, 5'd9, 4'b0000, 1'b1);
    step();
    st_issue_valid = 1'b0;
    step();
    @(negedge clock);
`ifdef STORE_MISALIGN_CHECK_EN
    chk("mis_exc", {63'd0, st_complete_exc}, 64'd1);
    chk("mis_mask", {60'd0, sq_packet.byte_mask}, 64'h0);
`else
    chk("mis_addr", {32'd0, sq_packet.store_addr}, 64'h1000);
    chk("mis_mask", {60'd0, sq_packet.byte_mask}, 64'hF);
    chk("mis_exc", {63'd0, st_complete_exc}, 64'd0);
`endif
    step();

    // reset while a store is stalled in S2
    st_complete_ack = 1'b0;
    drive(32'h5000, 32'h0, 32'h9999_9999, 2'd2, 3'd2, 5'd20, 4'b0000, 1'b0);
    step();
    st_issue_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    @(negedge clock);
    chk("rst_stall_cvalid", {63'd0, st_complete_valid}, 64'd0);
    chk("rst_stall_ready", {63'd0, st_issue_ready}, 64'd1);
    chk("rst_stall_tag", {59'd0, st_complete_rob_tag}, 64'd0);
    reset = 1'b0;
    st_complete_ack = 1'b1;
    step();
    @(negedge clock);
    chk("rst_stall_no_write", {56'd0, resolving_sq_mask}, 64'd0);
    step();

    // random back-to-back stream at full throughput
    for (int n = 0; n < 12; n++) begin
      drive($urandom, 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 2)),
            3'(n), 5'($urandom_range(0, 31)), 4'b0000, 1'b1);
      @(negedge clock);
      chk("thru_ready", {63'd0, st_issue_ready}, 64'd1);
      step();
    end
    st_issue_valid = 1'b0;

    // drain with a bounded wait
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
